seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller that shares one 8-bit seven-segment bus among NUM_DIGITS digit commons. It takes per-digit segment patterns from the bcd_to_seg_mod instances of the time-keeping blocks (hour/minute/second) and drives one digit per time slot. A blanking guard at the start of each slot suppresses ghosting. Data is snapshotted once per frame so a digit never changes partway through a frame.

---
 rtl/seg_scan_ctrl.sv | 102 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller with per-slot blank guard and per-frame snapshot
// Ports:
//   clk_in      system clock
//   rst         synchronous active-high reset
//   digit_data  8*NUM_DIGITS segment patterns, byte i drives digit i
//   digit_en    per-digit enable, 0 keeps the digit dark
//   dim         (only with SEG_SCAN_DIM_EN) 2-bit brightness shift, snapshotted per frame
//   seg_out     shared segment bus, active-high, registered
//   seg_com     digit commons, active-low, at most one low, registered
//   digit_idx   digit owning the current slot, registered
//   frame_start one-cycle pulse on cycle 0 of digit 0's slot
// Optional feature macro: SEG_SCAN_DIM_EN
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                            clk_in,
    input  logic                            rst,
    input  logic [8*NUM_DIGITS-1:0]         digit_data,
    input  logic [NUM_DIGITS-1:0]           digit_en,
`ifdef SEG_SCAN_DIM_EN
    input  logic [1:0]                      dim,
`endif
    output logic [7:0]                      seg_out,
    output logic [NUM_DIGITS-1:0]           seg_com,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
    output logic                            frame_start
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    typedef enum logic {BLANK, DRIVE} state_t;
    // c_q/idx_q/state_q describe the cycle the output registers will show next
    state_t                  state_q, state_d;
    logic [CW-1:0]           c_q, c_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [8*NUM_DIGITS-1:0] snap_data_q, data_eff;
    logic [NUM_DIGITS-1:0]   snap_en_q, en_eff;
    logic [7:0]              seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]   seg_com_q, seg_com_d;
    logic [IW-1:0]           digit_idx_q;
    logic                    frame_start_q, frame_start_d;
    logic                    last, on;
`ifdef SEG_SCAN_DIM_EN
    logic [1:0]              snap_dim_q, dim_eff;
`endif
    always_comb begin
        last          = c_q == CW'(SCAN_DIV - 1);
        c_d           = last ? '0 : c_q + CW'(1);
        idx_d         = last ? (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1)) : idx_q;
        state_d       = state_q == BLANK ? (c_q == CW'(BLANK_CYCLES - 1) ? DRIVE : BLANK)
                                         : (last ? BLANK : DRIVE);
        // the snapshot loads at the end of the frame_start cycle, so bypass it while it is being loaded
        data_eff      = frame_start_q ? digit_data : snap_data_q;
        en_eff        = frame_start_q ? digit_en : snap_en_q;
        on            = state_q == DRIVE && en_eff[idx_q];
`ifdef SEG_SCAN_DIM_EN
        dim_eff       = frame_start_q ? dim : snap_dim_q;
        on            = on && ((c_q - CW'(BLANK_CYCLES)) < (CW'(SCAN_DIV - BLANK_CYCLES) >> dim_eff));
`endif
        seg_out_d     = on ? data_eff[{idx_q, 3'b000} +: 8] : '0;
        seg_com_d     = on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        frame_start_d = c_q == '0 && idx_q == '0;
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= BLANK;
            c_q           <= '0;
            idx_q         <= '0;
            snap_data_q   <= '0;
            snap_en_q     <= '0;
            seg_out_q     <= '0;
            seg_com_q     <= '1;
            digit_idx_q   <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_q           <= c_d;
            idx_q         <= idx_d;
            seg_out_q     <= seg_out_d;
            seg_com_q     <= seg_com_d;
            digit_idx_q   <= idx_q;
            frame_start_q <= frame_start_d;
            if (frame_start_q) begin
                snap_data_q <= digit_data;
                snap_en_q   <= digit_en;
            end
        end
    end
`ifdef SEG_SCAN_DIM_EN
    always_ff @(posedge clk_in) begin
        if (rst)
            snap_dim_q <= '0;
        else if (frame_start_q)
            snap_dim_q <= dim;
    end
`endif
    assign seg_out     = seg_out_q;
    assign seg_com     = seg_com_q;
    assign digit_idx   = digit_idx_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2
module tb_seg_scan_ctrl;
    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 2;
    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digit_data = 32'h4F5B063F;
    logic [3:0]  digit_en = 4'hF;
    logic [1:0]  dim = 2'd0;
    logic [7:0]  seg_out;
    logic [3:0]  seg_com;
    logic [1:0]  digit_idx;
    logic        frame_start;
    seg_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .digit_data(digit_data),
        .digit_en(digit_en),
`ifdef SEG_SCAN_DIM_EN
        .dim(dim),
`endif
        .seg_out(seg_out),
        .seg_com(seg_com),
        .digit_idx(digit_idx),
        .frame_start(frame_start)
    );
    always #5 clk_in = ~clk_in;
    typedef struct {
        string      name;
        int         cyc;
        bit         full;
        logic [3:0] com;
        logic [7:0] so;
        logic [1:0] idx;
        logic       fs;
    } exp_t;
    typedef struct {
        int         ph;
        int         lo;
        int         hi;
        logic [3:0] com;
        logic [7:0] so;
    } hand_t;
    exp_t  q[$];
    hand_t ht[15];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_on = 1'b0;
    int    mt;
    logic [31:0] sd;
    logic [3:0]  se;
    logic [1:0]  sdm;
    always @(negedge clk_in) begin
        if (mon_on) begin
            n_cmp++;
            if ($countones(~seg_com) > 1) begin
                n_bad++;
                $display("FAIL excl: seg_com=%b has more than one low bit", seg_com);
            end
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (seg_com !== e.com || seg_out !== e.so ||
                (e.full && (digit_idx !== e.idx || frame_start !== e.fs))) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got com=%b out=%h idx=%0d fs=%b, want com=%b out=%h idx=%0d fs=%b (idx/fs checked=%0d)",
                         e.name, e.cyc, seg_com, seg_out, digit_idx, frame_start,
                         e.com, e.so, e.idx, e.fs, e.full);
            end
        end
    end
    task automatic run_phase(input int ph, input int ncyc);
        rst = 1'b1;
        digit_data = 32'h4F5B063F;
        digit_en = (ph == 2) ? 4'b1011 : 4'hF;
        dim = (ph == 4) ? 2'd2 : (ph == 5) ? 2'd3 : 2'd0;
        @(posedge clk_in);
        #1;
        mt = -1;
        sd = '0;
        se = '0;
        sdm = '0;
        mon_on = 1'b1;
        for (int k = -1; k < ncyc; k++) begin
            exp_t e;
            int   c;
            int   i;
            bit   on;
            if (ph == 1 && k == 5) digit_data[7:0] = 8'h7F;
            if (ph == 6) begin
                digit_data = $urandom;
                digit_en = 4'($urandom);
                dim = 2'($urandom);
            end
            rst = (ph == 3 && k == 13);
            e.name = "model";
            e.cyc = k;
            e.full = 1'b1;
            if (mt < 0) begin
                e.com = 4'hF;
                e.so = 8'h00;
                e.idx = 2'd0;
                e.fs = 1'b0;
            end else begin
                c = mt % S;
                i = (mt / S) % N;
                on = c >= B && se[i];
`ifdef SEG_SCAN_DIM_EN
                on = on && ((c - B) < ((S - B) >> sdm));
`endif
                e.com = on ? ~(4'b0001 << i) : 4'hF;
                e.so = on ? sd[8*i +: 8] : 8'h00;
                e.idx = 2'(i);
                e.fs = (c == 0 && i == 0);
            end
            q.push_back(e);
            foreach (ht[j]) begin
                if (ht[j].ph == ph && k >= ht[j].lo && k <= ht[j].hi) begin
                    exp_t h;
                    h.name = $sformatf("hand_p%0d", ph);
                    h.cyc = k;
                    h.full = 1'b0;
                    h.com = ht[j].com;
                    h.so = ht[j].so;
                    h.idx = 2'd0;
                    h.fs = 1'b0;
                    q.push_back(h);
                end
            end
            if (rst) begin
                mt = -1;
                sd = '0;
                se = '0;
                sdm = '0;
            end else begin
                if (mt >= 0 && e.fs) begin
                    sd = digit_data;
                    se = digit_en;
                    sdm = dim;
                end
                mt++;
            end
            @(posedge clk_in);
            #1;
        end
        mon_on = 1'b0;
    endtask
    initial begin
        ht = '{
            '{1, 0, 1, 4'hF, 8'h00}, '{1, 2, 7, 4'hE, 8'h3F}, '{1, 10, 15, 4'hD, 8'h06},
            '{1, 26, 31, 4'h7, 8'h4F}, '{1, 34, 39, 4'hE, 8'h7F}, '{1, 16, 17, 4'hF, 8'h00},
            '{2, 16, 23, 4'hF, 8'h00}, '{2, 24, 25, 4'hF, 8'h00}, '{2, 26, 31, 4'h7, 8'h4F},
            '{3, 14, 14, 4'hF, 8'h00}, '{3, 15, 16, 4'hF, 8'h00}, '{3, 17, 22, 4'hE, 8'h3F},
            '{4, 2, 2, 4'hE, 8'h3F}, '{4, 3, 7, 4'hF, 8'h00},
            '{5, 0, 7, 4'hF, 8'h00}
        };
        run_phase(1, 66);
        run_phase(2, 34);
        run_phase(3, 24);
`ifdef SEG_SCAN_DIM_EN
        run_phase(4, 10);
        run_phase(5, 10);
`endif
        run_phase(6, 10 * N * S);
        @(negedge clk_in);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
